// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, scan-out state type and pixel helpers
package fb_pkg;
  localparam int unsigned FB_WIDTH = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam logic [31:0] FB_BASE_ADDR = 32'h0001_0000;
  localparam int unsigned BYTES_PER_PIX = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} scan_state_e;
  function automatic logic [23:0] rgba_to_rgb(input logic [31:0] word);
    return word[31:8];
  endfunction
endpackage

// File: rtl/fb_sync_fifo.sv
// fb_sync_fifo: show-ahead synchronous FIFO with occupancy count
module fb_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: fetches one framebuffer frame over a req/gnt read port and streams RGB pixels
module fb_scanout_reader #(
  parameter int unsigned FB_WIDTH = fb_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT = fb_pkg::FB_HEIGHT,
  parameter logic [31:0] FB_BASE_ADDR = fb_pkg::FB_BASE_ADDR,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_rgb,
  output logic        pix_sof,
  output logic        pix_eol
);
  import fb_pkg::*;
  localparam int unsigned NPIX = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned IW = $clog2(NPIX + 1);
  localparam int unsigned XW = $clog2(FB_WIDTH + 1);
  localparam int unsigned YW = $clog2(FB_HEIGHT + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  scan_state_e state_q, state_d;
  logic [IW-1:0] req_idx_q, req_idx_d, out_idx_q, out_idx_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] outst_q, outst_d, fifo_count;
  logic err_q, err_d;
  logic [31:0] fifo_head;
  logic fire, push, pop, at_eol;
  fb_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .wdata(mem_rdata),
    .pop(pop),
    .rdata(fifo_head),
    .count(fifo_count)
  );
  // Credit covers both buffered and in-flight words, so the FIFO can never overflow
  assign mem_req = state_q == ST_FETCH &&
                   (CW+1)'(outst_q) + (CW+1)'(fifo_count) < (CW+1)'(FIFO_DEPTH);
  assign mem_addr = FB_BASE_ADDR + 32'(req_idx_q) * 32'(BYTES_PER_PIX);
  assign fire = mem_req && mem_gnt;
  assign push = mem_rvalid && outst_q != '0;
  assign pop = pix_valid && pix_ready;
  assign at_eol = x_q == XW'(FB_WIDTH - 1);
  assign busy = state_q == ST_FETCH || state_q == ST_DRAIN;
  assign frame_done = state_q == ST_DONE;
  assign err = err_q;
  assign pix_valid = fifo_count != '0;
  assign pix_rgb = pix_valid ? rgba_to_rgb(fifo_head) : '0;
  assign pix_sof = pix_valid && x_q == '0 && y_q == '0;
  assign pix_eol = pix_valid && at_eol;
  always_comb begin
    state_d = state_q;
    req_idx_d = req_idx_q;
    out_idx_d = pop ? out_idx_q + 1'b1 : out_idx_q;
    x_d = pop ? (at_eol ? '0 : x_q + 1'b1) : x_q;
    y_d = pop && at_eol ? y_q + 1'b1 : y_q;
    outst_d = outst_q + CW'(fire) - CW'(push);
    err_d = err_q || (mem_rvalid && outst_q == '0);
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_FETCH;
        req_idx_d = '0;
        out_idx_d = '0;
        x_d = '0;
        y_d = '0;
      end
      ST_FETCH: if (fire) begin
        req_idx_d = req_idx_q + 1'b1;
        state_d = req_idx_q == IW'(NPIX - 1) ? ST_DRAIN : ST_FETCH;
      end
      ST_DRAIN: state_d = out_idx_d == IW'(NPIX) ? ST_DONE : ST_DRAIN;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_idx_q <= '0;
      out_idx_q <= '0;
      x_q <= '0;
      y_q <= '0;
      outst_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_idx_q <= req_idx_d;
      out_idx_q <= out_idx_d;
      x_q <= x_d;
      y_q <= y_d;
      outst_q <= outst_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/fb_scanout_reader.md
Name: fb_scanout_reader

Overview:
Framebuffer scan-out engine; the read side of the pixel framebuffer that the CPU writes through memory stores.
- On a start pulse, fetches one full frame of 32-bit RGBA words (0xRRGGBBAA) from memory at FB_BASE_ADDR in raster order.
- Emits a valid/ready pixel stream of 24-bit RGB with start-of-frame and end-of-line markers, feeding a display or capture sink.
- Sits beside the CPU on a memory read port and arbitrates through a req/gnt handshake.

Parameters:
FB_WIDTH, 320, pixels per line
FB_HEIGHT, 240, lines per frame
FB_BASE_ADDR, 32'h0001_0000, byte address of pixel (0,0); must be 4-byte aligned
FIFO_DEPTH, 8, pixel buffer entries; power of 2, >=2; also the cap on in-flight reads

Ports:
clk  in  1  system clock
rst  in  1  reset (see Behaviour)
start  in  1  one-cycle pulse: begin one frame
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after last pixel handshake
err  out  1  sticky: mem_rvalid with zero outstanding; cleared only by rst
mem_req  out  1  read request valid
mem_addr  out  32  byte address of requested word
mem_gnt  in  1  request accepted this cycle (mem_req && mem_gnt)
mem_rvalid  in  1  read data valid; in order, any latency >=1
mem_rdata  in  32  RGBA word
pix_valid  out  1  pixel available
pix_ready  in  1  sink accepts pixel
pix_rgb  out  24  {R,G,B} = mem_rdata[31:8]; alpha dropped
pix_sof  out  1  high with pixel (0,0)
pix_eol  out  1  high with pixel x==FB_WIDTH-1

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - busy=0, frame_done=0, err=0, mem_req=0, mem_addr=FB_BASE_ADDR, pix_valid=0.
  - pix_sof=0, pix_eol=0, pix_rgb=0.
  - All counters, the FIFO and the outstanding-read count cleared.
- Reset mid-frame: the frame is abandoned and no frame_done is issued. The memory is reset by the same rst, so no stale responses arrive.
- FSM: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
  - IDLE: on start, go to FETCH, set busy=1, req_idx=0, out_idx=0.
  - FETCH: mem_req=1 whenever outstanding + fifo_count < FIFO_DEPTH (credit). mem_addr = FB_BASE_ADDR + 4*req_idx. On mem_gnt, increment req_idx and outstanding. After the grant for req_idx == W*H-1, go to DRAIN and drop mem_req the next cycle.
  - DRAIN: no requests. Go to DONE when out_idx reaches W*H, i.e. the last pixel handshake.
  - DONE: frame_done=1 for one cycle, busy=0, return to IDLE.
- start is ignored unless in IDLE. start arriving in the same cycle as DONE is ignored.
- mem_req/mem_addr stay stable while mem_req=1 && !mem_gnt (AXI-like; no withdrawal).
- Response path:
  - mem_rvalid pushes mem_rdata into the FIFO and decrements outstanding.
  - The credit rule guarantees no overflow; simultaneous push and pop is legal at any count.
  - mem_rvalid with outstanding==0: data dropped, err set.
- Output:
  - pix_valid = FIFO non-empty; pix_rgb is the FIFO head[31:8].
  - Pop on pix_valid && pix_ready. Zero-latency show-ahead FIFO (head visible the same cycle count>0).
  - pix_valid held and data stable until accepted.
- Markers come from out_idx via x/y counters:
  - sof when x==0 && y==0.
  - eol when x==FB_WIDTH-1.
  - x wraps to 0 and y increments at eol.
- Widths:
  - req_idx and out_idx are $clog2(W*H+1) bits.
  - Address computed in 32 bits, no wrap check; the base must satisfy FB_BASE_ADDR + 4*W*H <= 2^32.
- Latency:
  - First mem_req appears the cycle after start.
  - First pix_valid appears the cycle after the first mem_rvalid.
- Steady-state throughput is 1 pixel/cycle when gnt=1, rvalid latency <= FIFO_DEPTH-1, and pix_ready=1.

Decomposition:
- Package fb_pkg holds:
  - FB_WIDTH, FB_HEIGHT, FB_BASE_ADDR defaults, shared with the CPU-side address decode and the framebuffer bench.
  - Bytes-per-pixel constant (4).
  - Scan-out FSM state enum.
  - Function rgba_to_rgb(word) returning word[31:8].
- One sub-module: fb_sync_fifo, a parameterized depth/width show-ahead FIFO with count output. The reader instantiates it with width 32.

Test Plan:
- W=4,H=2, memory latency 1, gnt=1, pix_ready=1; memory word i = {i[7:0],8'hA0,8'h5B,8'hFF}:
  - 8 pixels pix_rgb = {i,A0,5B}; sof on pixel 0; eol on pixels 3 and 7.
  - mem_addr sequence 0x10000..0x1001C step 4.
  - frame_done exactly one cycle after the 8th handshake.
- Same frame with pix_ready=0 for cycles 3-30:
  - mem_req deasserts once outstanding+count=8; no FIFO overflow.
  - Pixel order and values unchanged on release.
- Random mem_gnt (50%) and rvalid latency 1-7 cycles, FIFO_DEPTH=8, 320x240 all 0x000000FF: 76800 pixels all rgb=0x000000, err=0, mem_addr never changes while stalled.
- start pulses during busy, and on the DONE cycle: ignored; exactly one frame_done per accepted start.
- rst asserted mid-frame at pixel 5: next cycle busy=0, pix_valid=0, mem_req=0; a fresh start produces a full frame beginning with sof.
- mem_rvalid injected while IDLE: err=1 and stays 1; no pix_valid generated.
